lector_contadores: RTL and testbench

- Requester side of the FIFO-occupancy counter query interface in the transaction layer.
- On a start pulse it sweeps counter indices 0..NUM_CNT-1, issuing one req/idx per index, and waits for each data/valid response.
- It stores each returned count in a snapshot register and replays each count on a one-cycle result strobe.
- It signals completion with done, and sets a sticky error flag if a response does not arrive within TIMEOUT cycles.

---
 rtl/lector_contadores.sv | 81 ++++++++
 tb/tb_lector_contadores.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lector_contadores.sv
// lector_contadores: sweeps NUM_CNT occupancy counters, snapshots each reply and flags missing replies
// clk/reset: system clock, synchronous active-high reset
// start: begin a sweep (accepted in IDLE only)
// data_in/valid_in: reply from the counter block; req/idx: query strobe and index held until reply
// data_out/idx_out/valid_out: one-cycle result strobe per index
// busy/done: sweep in progress / end-of-sweep pulse
// error: sticky timeout flag for the current or last sweep; snapshot: counts of the last sweep
module lector_contadores #(
   parameter int DATA_W  = 8,
   parameter int NUM_CNT = 5,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [DATA_W-1:0]         data_in,
   input  logic                      valid_in,
   output logic                      req,
   output logic [2:0]                idx,
   output logic [DATA_W-1:0]         data_out,
   output logic [2:0]                idx_out,
   output logic                      valid_out,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [NUM_CNT*DATA_W-1:0] snapshot
);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, NEXT, DONE} state_t;
   state_t state, state_n;
   logic [TW-1:0] tcnt;
   logic tout, last, fin;
   logic [DATA_W-1:0] cap;
   // tcnt holds the number of WAIT cycles already spent, so this is the TIMEOUT-th one
   assign tout = tcnt == TW'(TIMEOUT - 1);
   assign last = idx == 3'(NUM_CNT - 1);
   // a reply arriving on the expiring cycle still counts as a reply
   assign fin = state == WAIT && (valid_in || tout);
   assign cap = valid_in ? data_in : '0;
   assign req = state == REQ;
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start ? REQ : IDLE;
         REQ:     state_n = WAIT;
         WAIT:    state_n = (valid_in || tout) ? NEXT : WAIT;
         NEXT:    state_n = last ? DONE : REQ;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tcnt      <= '0;
         idx       <= '0;
         idx_out   <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         error     <= 1'b0;
         snapshot  <= '0;
      end else begin
         state     <= state_n;
         valid_out <= fin;
         if (state == IDLE && start) error <= 1'b0;
         if (state == REQ) tcnt <= '0;
         else if (state == WAIT && tcnt != TW'(TIMEOUT)) tcnt <= tcnt + 1'b1;
         if (fin) begin
            data_out <= cap;
            idx_out  <= idx;
            error    <= error | ~valid_in;
            for (int i = 0; i < NUM_CNT; i++)
               if (idx == 3'(i)) snapshot[i*DATA_W +: DATA_W] <= cap;
         end
         if (state == NEXT && !last) idx <= idx + 3'd1;
         if (state == DONE || (state == IDLE && start)) idx <= '0;
      end
   end
endmodule

// File: tb/tb_lector_contadores.sv
// tb_lector_contadores: directed bench for the counter sweep requester
module tb_lector_contadores;
   localparam int DW = 8;
   localparam int N = 5;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic valid_in, req, valid_out, busy, done, error;
   logic [DW-1:0] data_in, data_out;
   logic [2:0] idx, idx_out;
   logic [N*DW-1:0] snapshot;
   logic rvalid = 1'b0, spur = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic [DW-1:0] vals [8];
   logic [7:0] silent = '0;
   logic [2:0] ridx = '0;
   int lat = 1, rc = 0;
   int errors = 0, checks = 0, cyc = 0, nreq = 0, nvo = 0, ndone = 0;
   int req_cyc [128];
   logic [2:0] req_idx [128];
   logic [2:0] vo_idx [128];
   logic [DW-1:0] vo_data [128];

   assign valid_in = rvalid | spur;
   assign data_in = spur ? 8'hAA : rdata;

   lector_contadores #(.DATA_W(DW), .NUM_CNT(N), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in), .valid_in(valid_in),
      .req(req), .idx(idx), .data_out(data_out), .idx_out(idx_out), .valid_out(valid_out),
      .busy(busy), .done(done), .error(error), .snapshot(snapshot)
   );

   always #5 clk = ~clk;

   // responder: answers a req after lat cycles unless that index is silenced
   always @(negedge clk) begin
      rvalid = 1'b0;
      if (rc == 1) begin
         rvalid = !silent[ridx];
         rdata = vals[ridx];
      end
      if (rc > 0) rc = rc - 1;
      if (req && !reset) begin
         rc = lat;
         ridx = idx;
      end
   end

   always @(posedge clk) begin
      #2;
      cyc = cyc + 1;
      if (req) begin
         req_cyc[nreq % 128] = cyc;
         req_idx[nreq % 128] = idx;
         nreq = nreq + 1;
      end
      if (valid_out) begin
         vo_idx[nvo % 128] = idx_out;
         vo_data[nvo % 128] = data_out;
         nvo = nvo + 1;
      end
      if (done) ndone = ndone + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, want finished");
      $fatal(1);
   end

   task automatic setv(input logic [7:0] a, b, c, d, e);
      vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d; vals[4] = e;
      vals[5] = 0; vals[6] = 0; vals[7] = 0;
   endtask

   task automatic go();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done: got done=%b after %0d cycles, want 1", tag, done, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({req, valid_out, busy, done, error} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, want 00000", {req, valid_out, busy, done, error});
      end
      checks++;
      if ({idx, idx_out, data_out} !== 14'b0) begin
         errors++;
         $display("FAIL reset_data: got idx=%0d idx_out=%0d data_out=%0d, want 0", idx, idx_out, data_out);
      end
      checks++;
      if (snapshot !== '0) begin
         errors++;
         $display("FAIL reset_snapshot: got %h, want 0", snapshot);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int b, r, d;
      b = nvo; r = nreq; d = ndone;
      setv(3, 7, 0, 255, 12); lat = 1; silent = '0;
      go();
      checks++;
      if ({req, busy, idx} !== 5'b11000) begin
         errors++;
         $display("FAIL basic_first_req: got req=%b busy=%b idx=%0d, want 1 1 0", req, busy, idx);
      end
      wait_done("basic");
      checks++;
      if (nreq - r !== 5 || ndone - d !== 1) begin
         errors++;
         $display("FAIL basic_counts: got reqs=%0d dones=%0d, want 5 1", nreq - r, ndone - d);
      end
      for (int k = 1; k < N; k++) begin
         checks++;
         if (req_cyc[r + k] - req_cyc[r + k - 1] !== 3) begin
            errors++;
            $display("FAIL basic_spacing%0d: got %0d, want 3", k, req_cyc[r + k] - req_cyc[r + k - 1]);
         end
      end
      for (int k = 0; k < N; k++) begin
         checks++;
         if (vo_idx[b + k] !== 3'(k) || vo_data[b + k] !== vals[k]) begin
            errors++;
            $display("FAIL basic_vo%0d: got (%0d,%0d), want (%0d,%0d)", k, vo_idx[b + k], vo_data[b + k], k, vals[k]);
         end
      end
      checks++;
      if (snapshot !== {8'd12, 8'd255, 8'd0, 8'd7, 8'd3} || error !== 1'b0) begin
         errors++;
         $display("FAIL basic_snapshot: got %h err=%b, want 0cff000703 err=0", snapshot, error);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: got busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_missing();
      int b, r;
      b = nvo; r = nreq;
      setv(10, 20, 30, 40, 50); lat = 1; silent = 8'b00100;
      go();
      wait_done("missing");
      for (int k = 0; k < N; k++) begin
         checks++;
         if (vo_idx[b + k] !== 3'(k) || vo_data[b + k] !== (k == 2 ? 8'd0 : vals[k])) begin
            errors++;
            $display("FAIL missing_vo%0d: got (%0d,%0d), want (%0d,%0d)", k, vo_idx[b + k], vo_data[b + k], k, k == 2 ? 0 : vals[k]);
         end
      end
      checks++;
      if (req_cyc[r + 3] - req_cyc[r + 2] !== 17) begin
         errors++;
         $display("FAIL missing_wait: got %0d, want 17", req_cyc[r + 3] - req_cyc[r + 2]);
      end
      checks++;
      if (snapshot !== {8'd50, 8'd40, 8'd0, 8'd20, 8'd10} || error !== 1'b1) begin
         errors++;
         $display("FAIL missing_snapshot: got %h err=%b, want 322800140a err=1", snapshot, error);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (error !== 1'b1) begin
         errors++;
         $display("FAIL missing_sticky: got error=%b, want 1", error);
      end
      silent = '0;
   endtask

   task automatic test_slow();
      int b, r;
      b = nvo; r = nreq;
      setv(1, 2, 3, 4, 5); lat = 4;
      go();
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL slow_error_clear: got error=%b, want 0", error);
      end
      wait_done("slow");
      for (int k = 1; k < N; k++) begin
         checks++;
         if (req_cyc[r + k] - req_cyc[r + k - 1] !== 6) begin
            errors++;
            $display("FAIL slow_spacing%0d: got %0d, want 6", k, req_cyc[r + k] - req_cyc[r + k - 1]);
         end
      end
      checks++;
      if (snapshot !== {8'd5, 8'd4, 8'd3, 8'd2, 8'd1} || error !== 1'b0 || nvo - b !== 5) begin
         errors++;
         $display("FAIL slow_snapshot: got %h err=%b vo=%0d, want 0504030201 err=0 vo=5", snapshot, error, nvo - b);
      end
   endtask

   task automatic test_spurious();
      int b, r, d;
      b = nvo;
      @(negedge clk); spur = 1'b1;
      @(negedge clk); spur = 1'b0;
      @(negedge clk);
      checks++;
      if (nvo !== b || snapshot !== {8'd5, 8'd4, 8'd3, 8'd2, 8'd1} || busy !== 1'b0) begin
         errors++;
         $display("FAIL spur_idle: got vo=%0d snap=%h busy=%b, want vo=0 snap=0504030201 busy=0", nvo - b, snapshot, busy);
      end
      r = nreq; d = ndone;
      setv(9, 8, 7, 6, 5); lat = 3;
      go();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done("spur");
      repeat (10) @(negedge clk);
      checks++;
      if (nreq - r !== 5 || ndone - d !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL spur_sweeps: got reqs=%0d dones=%0d busy=%b, want 5 1 0", nreq - r, ndone - d, busy);
      end
      checks++;
      if (snapshot !== {8'd5, 8'd6, 8'd7, 8'd8, 8'd9}) begin
         errors++;
         $display("FAIL spur_snapshot: got %h, want 0506070809", snapshot);
      end
   endtask

   task automatic test_reset_mid();
      int n, b, r, d;
      setv(11, 12, 13, 14, 15); lat = 2;
      go();
      n = 0;
      while (!(req && idx == 3'd3) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!(req && idx == 3'd3)) begin
         errors++;
         $display("FAIL mid_reach_idx3: got req=%b idx=%0d, want 1 3", req, idx);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({req, valid_out, busy, done, error, idx, idx_out, data_out} !== 19'b0 || snapshot !== '0) begin
         errors++;
         $display("FAIL mid_reset: got req=%b vo=%b busy=%b done=%b err=%b idx=%0d snap=%h, want all 0", req, valid_out, busy, done, error, idx, snapshot);
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      b = nvo; r = nreq; d = ndone; lat = 1;
      go();
      wait_done("mid");
      for (int k = 0; k < N; k++) begin
         checks++;
         if (req_idx[r + k] !== 3'(k) || vo_data[b + k] !== vals[k]) begin
            errors++;
            $display("FAIL mid_sweep%0d: got idx=%0d data=%0d, want %0d %0d", k, req_idx[r + k], vo_data[b + k], k, vals[k]);
         end
      end
      checks++;
      if (snapshot !== {8'd15, 8'd14, 8'd13, 8'd12, 8'd11} || ndone - d !== 1) begin
         errors++;
         $display("FAIL mid_snapshot: got %h dones=%0d, want 0f0e0d0c0b 1", snapshot, ndone - d);
      end
   endtask

   task automatic test_boundary();
      int r;
      r = nreq;
      setv(21, 22, 23, 24, 25); lat = 15;
      go();
      wait_done("boundary");
      checks++;
      if (req_cyc[r + 1] - req_cyc[r] !== 17) begin
         errors++;
         $display("FAIL boundary_spacing: got %0d, want 17", req_cyc[r + 1] - req_cyc[r]);
      end
      checks++;
      if (snapshot !== {8'd25, 8'd24, 8'd23, 8'd22, 8'd21} || error !== 1'b0) begin
         errors++;
         $display("FAIL boundary_capture: got %h err=%b, want 1918171615 err=0", snapshot, error);
      end
   endtask

   task automatic test_back_to_back();
      int r, d;
      setv(1, 2, 4, 8, 16); lat = 1;
      go();
      wait_done("b2b_a");
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      r = nreq;
      repeat (4) @(negedge clk);
      checks++;
      if (nreq !== r || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_start_in_done: got reqs=%0d busy=%b, want 0 0", nreq - r, busy);
      end
      go();
      wait_done("b2b_b");
      d = ndone;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      checks++;
      if ({req, busy, idx} !== 5'b11000) begin
         errors++;
         $display("FAIL b2b_immediate: got req=%b busy=%b idx=%0d, want 1 1 0", req, busy, idx);
      end
      wait_done("b2b_c");
      checks++;
      if (snapshot !== {8'd16, 8'd8, 8'd4, 8'd2, 8'd1} || ndone - d !== 1) begin
         errors++;
         $display("FAIL b2b_snapshot: got %h dones=%0d, want 1008040201 1", snapshot, ndone - d);
      end
   endtask

   initial begin
      setv(0, 0, 0, 0, 0);
      test_reset();
      test_basic();
      test_missing();
      test_slow();
      test_spurious();
      test_reset_mid();
      test_boundary();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
